// File: rtl/mist_rom_loader.sv
// ROM download front end: packs data_io bytes into words and queues them per region; owns rom_loaded and core reset.
// Optional: define LOADER_CHECKSUM_EN for a 16-bit running byte checksum on the checksum port.
module mist_rom_loader #(
  parameter int                    ROM_INDEX      = 0,
  parameter int                    BYTES_PER_WORD = 2,
  parameter int                    REGIONS        = 4,
  parameter logic [REGIONS*25-1:0] REGION_END     = {25'h10000, 25'h18000, 25'h1C000, 25'h1FFFFFF},
  parameter int                    RESET_HOLD     = 255,
  localparam int                   DW             = 8*BYTES_PER_WORD
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          reset_req,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic [2:0]    wr_region,
  output logic [24:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rom_loaded,
  output logic          core_reset,
  output logic          overflow,
  output logic [15:0]   checksum
);

  localparam int SH = (BYTES_PER_WORD == 2) ? 1 : 0;

  typedef struct packed {
    logic [2:0]    region;
    logic [24:0]   addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic          vld;
    logic [2:0]    region;
    logic [24:0]   waddr;
    logic [24:0]   gaddr;
    logic [DW-1:0] data;
  } pack_t;

  typedef enum logic [1:0] {S_HOLD, S_COUNT, S_RUN} state_t;

  // REGION_END is written ascending left to right, so region 0 sits in the top slice.
  function automatic logic [24:0] end_of(input int i);
    return REGION_END[(REGIONS-1-i)*25 +: 25];
  endfunction

  logic        dl_q;
  logic        is_rom, acc, dl_rise_rom, dl_fall, dl_fall_rom;

  assign is_rom      = (ioctl_index == 8'(ROM_INDEX));
  assign acc         = ioctl_wr && ioctl_download && is_rom;
  assign dl_rise_rom = ioctl_download && !dl_q && is_rom;
  assign dl_fall     = !ioctl_download && dl_q;
  assign dl_fall_rom = dl_fall && is_rom;

  logic [2:0]  reg_sel;
  logic [24:0] reg_base, prev_end;
  logic        in_range;

  always_comb begin
    reg_sel  = '0;
    reg_base = '0;
    in_range = 1'b0;
    prev_end = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (!in_range && (ioctl_addr < end_of(i))) begin
        reg_sel  = 3'(i);
        reg_base = prev_end;
        in_range = 1'b1;
      end
      prev_end = end_of(i);
    end
  end

  logic [24:0] gaddr, waddr;
  logic        lane, last_lane;

  assign gaddr     = ioctl_addr >> SH;
  assign waddr     = (ioctl_addr - reg_base) >> SH;
  assign lane      = (BYTES_PER_WORD == 2) ? ioctl_addr[0] : 1'b0;
  assign last_lane = (BYTES_PER_WORD == 2) ? lane : 1'b1;

  pack_t pk_q, pk_d, cur;
  ent_t  ent_a, ent_b;
  logic  push_a, push_b, drop_addr, same;

  // Up to two pushes per cycle: A flushes the old pending word, B emits a completed word.
  always_comb begin
    pk_d      = pk_q;
    push_a    = 1'b0;
    push_b    = 1'b0;
    drop_addr = 1'b0;
    same      = 1'b0;
    cur       = '0;
    ent_a     = '{region: pk_q.region, addr: pk_q.waddr, data: pk_q.data};
    ent_b     = '0;
    if (dl_fall && pk_q.vld) begin
      push_a   = 1'b1;
      pk_d.vld = 1'b0;
    end
    if (acc) begin
      if (!in_range) begin
        drop_addr = 1'b1;
      end else begin
        same = pk_q.vld && (pk_q.gaddr == gaddr) && (pk_q.region == reg_sel);
        if (pk_q.vld && !same) push_a = 1'b1;
        if (same) cur = pk_q;
        else      cur = '{vld: 1'b1, region: reg_sel, waddr: waddr, gaddr: gaddr, data: {DW{1'b1}}};
        cur.data[int'(lane)*8 +: 8] = ioctl_dout;
        if (last_lane) begin
          push_b = 1'b1;
          ent_b  = '{region: cur.region, addr: cur.waddr, data: cur.data};
          pk_d   = '0;
        end else begin
          pk_d = cur;
        end
      end
    end
  end

  ent_t       f0_q, f0_d, f1_q, f1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop, fifo_drop;

  assign pop = wr_ack && (cnt_q != 2'd0);

  always_comb begin
    f0_d      = f0_q;
    f1_d      = f1_q;
    cnt_d     = cnt_q;
    fifo_drop = 1'b0;
    if (pop) begin
      f0_d  = f1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push_a) begin
      case (cnt_d)
        2'd0:    begin f0_d = ent_a; cnt_d = 2'd1; end
        2'd1:    begin f1_d = ent_a; cnt_d = 2'd2; end
        default: fifo_drop = 1'b1;
      endcase
    end
    if (push_b) begin
      case (cnt_d)
        2'd0:    begin f0_d = ent_b; cnt_d = 2'd1; end
        2'd1:    begin f1_d = ent_b; cnt_d = 2'd2; end
        default: fifo_drop = 1'b1;
      endcase
    end
  end

  logic ld_pend_q, ld_pend_d, rom_loaded_q, rom_loaded_d, ovf_q, ovf_d;

  always_comb begin
    ld_pend_d    = (ld_pend_q || dl_fall_rom) && (cnt_d != 2'd0);
    rom_loaded_d = rom_loaded_q || ((ld_pend_q || dl_fall_rom) && (cnt_d == 2'd0));
    ovf_d        = ovf_q || drop_addr || fifo_drop;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q         <= 1'b0;
      pk_q         <= '0;
      f0_q         <= '0;
      f1_q         <= '0;
      cnt_q        <= '0;
      ld_pend_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      pk_q         <= pk_d;
      f0_q         <= f0_d;
      f1_q         <= f1_d;
      cnt_q        <= cnt_d;
      ld_pend_q    <= ld_pend_d;
      rom_loaded_q <= rom_loaded_d;
      ovf_q        <= ovf_d;
    end
  end

  state_t     state_q;
  logic [7:0] hold_cnt_q;
  logic       core_reset_q, cause;

  assign cause = reset_req || (ioctl_download && is_rom) || !rom_loaded_q;

  // HOLD with RESET_HOLD=0 goes straight to RUN, so RUN lands RESET_HOLD+1 cycles after causes clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= 8'(RESET_HOLD);
      core_reset_q <= 1'b1;
    end else if (cause) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= 8'(RESET_HOLD);
      core_reset_q <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD, S_COUNT: begin
          if (hold_cnt_q == 8'd0) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
          end else begin
            state_q    <= S_COUNT;
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end
        default: core_reset_q <= 1'b0;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (dl_rise_rom) cks_d = '0;
    if (acc)         cks_d = cks_d + {8'h00, ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cks_q <= '0;
    else          cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

  assign wr_req     = (cnt_q != 2'd0);
  assign wr_region  = f0_q.region;
  assign wr_addr    = f0_q.addr;
  assign wr_data    = f0_q.data;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mist_rom_loader.sv
// Scoreboard bench for mist_rom_loader: directed downloads, FIFO backpressure, reset sequencing.
module tb_mist_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        reset_req;
  logic        wr_req;
  logic        wr_ack;
  logic [2:0]  wr_region;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        rom_loaded;
  logic        core_reset;
  logic        overflow;
  logic [15:0] checksum;

  mist_rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .reset_req(reset_req), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_region(wr_region), .wr_addr(wr_addr), .wr_data(wr_data), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [2:0]  r;
    logic [24:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cks_model = '0;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_w(input logic [2:0] r, input logic [24:0] a, input logic [15:0] d);
    sb.push_back('{r: r, a: a, d: d});
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd0) cks_model = '0;
    step();
  endtask

  task automatic byte_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
    step();
    if (ioctl_download && ioctl_index == 8'd0) cks_model = cks_model + {8'h00, d};
  endtask

  task automatic chk_cks(input string nm);
`ifdef LOADER_CHECKSUM_EN
    chk(nm, 32'(checksum), 32'(cks_model));
`else
    chk(nm, 32'(checksum), 32'h0);
`endif
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (reset_n && wr_req && wr_ack) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got r%0d a%0h d%0h with empty scoreboard", wr_region, wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          if ({wr_region, wr_addr, wr_data} !== e) begin
            errors++;
            $display("FAIL word: got r%0d a%0h d%0h expected r%0d a%0h d%0h",
                     wr_region, wr_addr, wr_data, e.r, e.a, e.d);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; reset_req = 1'b0; wr_ack = 1'b1;
    repeat (3) step();
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_wr_region", 32'(wr_region), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rom_loaded", 32'(rom_loaded), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_checksum", 32'(checksum), 0);
    reset_n = 1'b1;
    repeat (20) step();
    chk("idle_core_reset", 32'(core_reset), 1);
    chk("idle_rom_loaded", 32'(rom_loaded), 0);
    chk("idle_wr_req", 32'(wr_req), 0);

    // Basic word, then reset release timing
    exp_w(3'd0, 25'h0, 16'h1234);
    dl_start(8'd0);
    byte_wr(25'h0, 8'h34);
    byte_wr(25'h1, 8'h12);
    chk("rom_loaded_during_dl", 32'(rom_loaded), 0);
    ioctl_download = 1'b0;
    step();
    chk("rom_loaded_after_fall", 32'(rom_loaded), 1);
    chk("core_reset_after_fall", 32'(core_reset), 1);
    chk_cks("cks_basic");
    repeat (255) step();
    chk("core_reset_hold_end", 32'(core_reset), 1);
    step();
    chk("core_reset_release", 32'(core_reset), 0);

    // reset_req pulse in RUN
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    chk("rst_req_assert", 32'(core_reset), 1);
    repeat (255) step();
    chk("rst_req_hold_end", 32'(core_reset), 1);
    step();
    chk("rst_req_release", 32'(core_reset), 0);

    // Non-ROM index is ignored
    dl_start(8'd1);
    byte_wr(25'h0, 8'h99);
    byte_wr(25'h1, 8'h98);
    ioctl_download = 1'b0;
    repeat (2) step();
    chk("idx1_wr_req", 32'(wr_req), 0);
    chk("idx1_core_reset", 32'(core_reset), 0);
    chk("idx1_rom_loaded", 32'(rom_loaded), 1);

    // Region boundaries, address-change flush, double push, end flush
    dl_start(8'd0);
    chk("redl_core_reset", 32'(core_reset), 1);
    chk("redl_rom_loaded", 32'(rom_loaded), 1);
    exp_w(3'd0, 25'h7FFF, 16'hAAFF);
    byte_wr(25'hFFFF, 8'hAA);
    byte_wr(25'h10000, 8'hBB);
    exp_w(3'd1, 25'h0, 16'hFFBB);
    exp_w(3'd2, 25'h0, 16'h2211);
    byte_wr(25'h18000, 8'h11);
    byte_wr(25'h18001, 8'h22);
    exp_w(3'd3, 25'h0, 16'hFF77);
    exp_w(3'd3, 25'h1, 16'h66FF);
    byte_wr(25'h1C000, 8'h77);
    byte_wr(25'h1C003, 8'h66);
    exp_w(3'd3, 25'h4, 16'hFF88);
    byte_wr(25'h1C008, 8'h88);
    ioctl_download = 1'b0;
    repeat (3) step();
    chk("regions_overflow", 32'(overflow), 0);
    chk_cks("cks_regions");

    // Backpressure: two words held, third dropped
    dl_start(8'd0);
    wr_ack = 1'b0;
    exp_w(3'd0, 25'h10, 16'h0201);
    exp_w(3'd0, 25'h11, 16'h0403);
    byte_wr(25'h20, 8'h01);
    byte_wr(25'h21, 8'h02);
    byte_wr(25'h22, 8'h03);
    byte_wr(25'h23, 8'h04);
    chk("bp_head_addr_2", 32'(wr_addr), 32'h10);
    chk("bp_overflow_2", 32'(overflow), 0);
    byte_wr(25'h24, 8'h05);
    byte_wr(25'h25, 8'h06);
    step();
    chk("bp_wr_req", 32'(wr_req), 1);
    chk("bp_head_addr", 32'(wr_addr), 32'h10);
    chk("bp_head_data", 32'(wr_data), 32'h0201);
    chk("bp_overflow", 32'(overflow), 1);
    wr_ack = 1'b1;
    repeat (3) step();
    chk("bp_drained", 32'(wr_req), 0);
    ioctl_download = 1'b0;
    repeat (2) step();

    // Reset mid-download discards pending byte
    dl_start(8'd0);
    byte_wr(25'h40, 8'hEE);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    cks_model = '0;
    step();
    chk("mid_rst_rom_loaded", 32'(rom_loaded), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_core_reset", 32'(core_reset), 1);
    chk("mid_rst_wr_req", 32'(wr_req), 0);
    chk("mid_rst_checksum", 32'(checksum), 0);
    reset_n = 1'b1;
    step();
    dl_start(8'd0);
    byte_wr(25'h1FFFFFF, 8'h55);
    chk("oob_overflow", 32'(overflow), 1);
    chk("oob_wr_req", 32'(wr_req), 0);
    exp_w(3'd0, 25'h20, 16'hCDFF);
    byte_wr(25'h41, 8'hCD);
    ioctl_download = 1'b0;
    step();
    chk("reload_rom_loaded", 32'(rom_loaded), 1);
    chk_cks("cks_reload");

    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
